pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage pipeline; one instance per boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries PC, instruction, valid bit and a sideband field.
- Resolves the shared stall vector into pass, hold or bubble, and adds a priority flush.
- Provides a registered stage-state indication and saturating performance counters (bubbles, held cycles, flushes).

Parameters:
- ADDR_W, 32, PC width.
- DATA_W, 32, instruction/payload width.
- SIDE_W, 8, sideband width (exception/control bits); minimum 1.
- STALL_W, 6, width of global stall vector.
- STAGE_IDX, 1, index of upstream stage in stall vector; legal range 0..STALL_W-2.
- NOP_VALUE, 0, DATA_W-wide value loaded into out_instr on bubble/flush/reset.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  STALL_W  global stall vector; bit k set = stage k stalled.
- flush  in  1  kill contents of this boundary (branch/exception redirect).
- cnt_clr  in  1  synchronous clear of all three counters.
- in_pc  in  ADDR_W  upstream PC.
- in_instr  in  DATA_W  upstream instruction.
- in_side  in  SIDE_W  upstream sideband.
- in_valid  in  1  upstream slot holds a real instruction.
- out_pc  out  ADDR_W  registered PC.
- out_instr  out  DATA_W  registered instruction.
- out_side  out  SIDE_W  registered sideband.
- out_valid  out  1  registered valid.
- state  out  2  last action: 0 RUN, 1 HOLD, 2 BUBBLE, 3 FLUSH.
- bubble_cnt  out  CNT_W  bubbles inserted.
- hold_cnt  out  CNT_W  cycles held.
- flush_cnt  out  CNT_W  flushes taken.

Behaviour:
- Definitions: up = stall[STAGE_IDX], dn = stall[STAGE_IDX+1].
- Reset:
  - out_pc = 0, out_instr = NOP_VALUE, out_side = 0, out_valid = 0.
  - state = RUN (0).
  - All counters = 0.
  - Reset overrides flush, stall and cnt_clr in the same cycle.
- Priority per cycle (first match wins):
  1. reset.
  2. flush: out_pc = 0, out_instr = NOP_VALUE, out_side = 0, out_valid = 0; state = FLUSH.
  3. up = 1 and dn = 0: bubble; same payload as flush; state = BUBBLE.
  4. up = 1 and dn = 1: hold; all payload outputs and out_valid unchanged; state = HOLD.
  5. up = 0: pass; out_* <= in_*, out_valid <= in_valid; state = RUN. dn is ignored here because the stall unit never asserts a downstream stall without the upstream one.
- Latency: one cycle from input to output on pass. There is no combinational path from any input to any output.
- State is a registered state machine with legal transitions between any pair of states. It is encoded exactly as listed above and is a pure function of the previous cycle's decision.
- Counters:
  - bubble_cnt increments on each BUBBLE cycle; hold_cnt on each HOLD cycle; flush_cnt on each FLUSH cycle.
  - Each counter saturates at 2^CNT_W-1; no wrap.
  - cnt_clr zeroes all counters that cycle. An event in the same cycle is not counted, so the counter reads 0 next cycle.
  - Counters are not affected by flush or stall except as events.
- Boundaries:
  - Flush during hold discards the held instruction and counts as a flush, not a hold.
  - Back-to-back flushes each count.
  - A bubble with in_valid = 0 still counts as a bubble.
  - Reset asserted mid-hold clears everything on that edge. On the first cycle after reset deassertion, normal priority applies.
- STAGE_IDX out of range is a configuration error; the block is not required to detect it.

Test Plan:
- Reset with in_pc=0x0000_0040, in_valid=1 and all stall bits 0 -> after the edge: out_pc=0, out_instr=NOP_VALUE, out_valid=0, state=0, all counters 0. Deassert reset -> next edge out_pc=0x40, out_valid=1, state=0.
- Stream PCs 0x00, 0x04, 0x08 with stall=0 -> outputs follow with exactly 1-cycle latency; hold_cnt, bubble_cnt and flush_cnt stay 0.
- STAGE_IDX=1, load PC 0x10, then stall=6'b000110 for 3 cycles -> out_pc stays 0x10, out_valid=1, state=1, hold_cnt=3.
- STAGE_IDX=1, stall=6'b000010 with in_pc=0x20 -> out_pc=0, out_instr=NOP_VALUE, out_valid=0, state=2, bubble_cnt=1.
- Hold PC 0x30 with stall=6'b000110, then assert flush -> out_valid=0, out_pc=0, state=3, flush_cnt=1, hold_cnt unchanged.
- CNT_W=2: 5 consecutive bubbles -> bubble_cnt=3 (saturated). Then cnt_clr together with a bubble -> bubble_cnt=0 next cycle.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Payload bundle crossing one pipeline boundary: upstream slot in, registered slot out.
// The master drives the upstream slot; the slave (the boundary register) drives the registered slot.
interface pipe_stage_reg_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SIDE_W = 8
);
  logic [ADDR_W-1:0] in_pc;
  logic [DATA_W-1:0] in_instr;
  logic [SIDE_W-1:0] in_side;
  logic              in_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_instr;
  logic [SIDE_W-1:0] out_side;
  logic              out_valid;

  modport master (
    output in_pc, in_instr, in_side, in_valid,
    input  out_pc, out_instr, out_side, out_valid
  );

  modport slave (
    input  in_pc, in_instr, in_side, in_valid,
    output out_pc, out_instr, out_side, out_valid
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: resolves stall/flush into pass, hold or bubble,
// reports the last action and keeps saturating bubble/hold/flush counters.
module pipe_stage_reg #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                SIDE_W    = 8,
  parameter int                STALL_W   = 6,
  parameter int                STAGE_IDX = 1,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cnt_clr,
  pipe_stage_reg_if.slave    bus,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_BUBBLE = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic ev);
    if (ev && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
    return c;
  endfunction

  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [DATA_W-1:0] instr_d, instr_q;
  logic [SIDE_W-1:0] side_d, side_q;
  logic              valid_d, valid_q;
  state_e            state_d, state_q;
  logic [CNT_W-1:0]  bubble_d, bubble_q;
  logic [CNT_W-1:0]  hold_d, hold_q;
  logic [CNT_W-1:0]  flush_d, flush_q;
  logic              up, dn;

  always_comb begin
    up = stall[STAGE_IDX];
    dn = stall[STAGE_IDX+1];

    if (flush)          state_d = ST_FLUSH;
    else if (up && !dn) state_d = ST_BUBBLE;
    else if (up)        state_d = ST_HOLD;
    else                state_d = ST_RUN;

    pc_d    = pc_q;
    instr_d = instr_q;
    side_d  = side_q;
    valid_d = valid_q;
    case (state_d)
      ST_FLUSH, ST_BUBBLE: begin
        pc_d    = '0;
        instr_d = NOP_VALUE;
        side_d  = '0;
        valid_d = 1'b0;
      end
      ST_RUN: begin
        pc_d    = bus.in_pc;
        instr_d = bus.in_instr;
        side_d  = bus.in_side;
        valid_d = bus.in_valid;
      end
      default: ;
    endcase

    // A clear wins over a same-cycle event so the counter reads zero afterwards.
    if (cnt_clr) begin
      bubble_d = '0;
      hold_d   = '0;
      flush_d  = '0;
    end else begin
      bubble_d = sat_inc(bubble_q, state_d == ST_BUBBLE);
      hold_d   = sat_inc(hold_q,   state_d == ST_HOLD);
      flush_d  = sat_inc(flush_q,  state_d == ST_FLUSH);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      instr_q  <= NOP_VALUE;
      side_q   <= '0;
      valid_q  <= 1'b0;
      state_q  <= ST_RUN;
      bubble_q <= '0;
      hold_q   <= '0;
      flush_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      side_q   <= side_d;
      valid_q  <= valid_d;
      state_q  <= state_d;
      bubble_q <= bubble_d;
      hold_q   <= hold_d;
      flush_q  <= flush_d;
    end
  end

  assign bus.out_pc    = pc_q;
  assign bus.out_instr = instr_q;
  assign bus.out_side  = side_q;
  assign bus.out_valid = valid_q;
  assign state         = state_q;
  assign bubble_cnt    = bubble_q;
  assign hold_cnt      = hold_q;
  assign flush_cnt     = flush_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboarded bench for pipe_stage_reg: a wide-counter and a 2-bit-counter instance
// share the same stimulus; a behavioural model predicts every registered output.
module tb_pipe_stage_reg;
  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          SIDE_W = 8;
  localparam int          STALL_W = 6;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic               clk = 1'b0;
  logic               reset;
  logic [STALL_W-1:0] stall;
  logic               flush, cnt_clr;
  logic [1:0]         state_a, state_b;
  logic [15:0]        bub_a, hold_a, fl_a;
  logic [1:0]         bub_b, hold_b, fl_b;

  pipe_stage_reg_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIDE_W(SIDE_W)) bus_a ();
  pipe_stage_reg_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIDE_W(SIDE_W)) bus_b ();

  pipe_stage_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIDE_W(SIDE_W), .STALL_W(STALL_W),
                   .STAGE_IDX(1), .NOP_VALUE(NOP), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .bus(bus_a.slave), .state(state_a), .bubble_cnt(bub_a), .hold_cnt(hold_a), .flush_cnt(fl_a));

  pipe_stage_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIDE_W(SIDE_W), .STALL_W(STALL_W),
                   .STAGE_IDX(1), .NOP_VALUE(NOP), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .bus(bus_b.slave), .state(state_b), .bubble_cnt(bub_b), .hold_cnt(hold_b), .flush_cnt(fl_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, instr;
    logic [7:0]  side;
    logic        valid;
    int          st;
    int          b16, h16, f16, b2, h2, f2;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int bump(input int c, input bit ev, input int maxv, input bit clr);
    if (clr) return 0;
    if (ev) return (c + 1 > maxv) ? maxv : c + 1;
    return c;
  endfunction

  // One clock of stimulus; the model's prediction for the following edge is queued.
  task automatic cyc(input bit r, input logic [5:0] s, input bit f, input bit c,
                     input logic [31:0] pc, input logic [31:0] ins, input logic [7:0] sd,
                     input bit v);
    int act;
    @(negedge clk);
    reset = r; stall = s; flush = f; cnt_clr = c;
    bus_a.in_pc = pc; bus_a.in_instr = ins; bus_a.in_side = sd; bus_a.in_valid = v;
    bus_b.in_pc = pc; bus_b.in_instr = ins; bus_b.in_side = sd; bus_b.in_valid = v;
    if (r) begin
      m.pc = 0; m.instr = NOP; m.side = 0; m.valid = 0; m.st = 0;
      m.b16 = 0; m.h16 = 0; m.f16 = 0; m.b2 = 0; m.h2 = 0; m.f2 = 0;
    end else begin
      if (f) act = 3;
      else if (s[1] == 1'b0) act = 0;
      else act = s[2] ? 1 : 2;
      if (act >= 2) begin
        m.pc = 0; m.instr = NOP; m.side = 0; m.valid = 0;
      end else if (act == 0) begin
        m.pc = pc; m.instr = ins; m.side = sd; m.valid = v;
      end
      m.st  = act;
      m.b16 = bump(m.b16, act == 2, 65535, c);
      m.h16 = bump(m.h16, act == 1, 65535, c);
      m.f16 = bump(m.f16, act == 3, 65535, c);
      m.b2  = bump(m.b2,  act == 2, 3, c);
      m.h2  = bump(m.h2,  act == 1, 3, c);
      m.f2  = bump(m.f2,  act == 3, 3, c);
    end
    sb.push_back(m);
  endtask

  task automatic pass(input logic [31:0] pc);
    cyc(0, 6'b000000, 0, 0, pc, $urandom, 8'($urandom), 1);
  endtask

  // Monitor: the register presents a new result after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_pc",    bus_a.out_pc, e.pc);
        chk("out_instr", bus_a.out_instr, e.instr);
        chk("out_side",  bus_a.out_side, e.side);
        chk("out_valid", bus_a.out_valid, e.valid);
        chk("state",     state_a, e.st);
        chk("bubble_cnt", bub_a, e.b16);
        chk("hold_cnt",   hold_a, e.h16);
        chk("flush_cnt",  fl_a, e.f16);
        chk("b_out_pc",   bus_b.out_pc, e.pc);
        chk("b_state",    state_b, e.st);
        chk("b_bubble_cnt", bub_b, e.b2);
        chk("b_hold_cnt",   hold_b, e.h2);
        chk("b_flush_cnt",  fl_b, e.f2);
      end
    end
  end

  initial begin
    int wait_cnt;
    reset = 1; stall = 0; flush = 0; cnt_clr = 0;
    bus_a.in_pc = 0; bus_a.in_instr = 0; bus_a.in_side = 0; bus_a.in_valid = 0;
    bus_b.in_pc = 0; bus_b.in_instr = 0; bus_b.in_side = 0; bus_b.in_valid = 0;

    cyc(1, 6'b000000, 0, 0, 32'h40, 32'hdead_beef, 8'h5a, 1);
    cyc(0, 6'b000000, 0, 0, 32'h40, 32'hdead_beef, 8'h5a, 1);
    pass(32'h00); pass(32'h04); pass(32'h08);
    pass(32'h10);
    repeat (3) cyc(0, 6'b000110, 0, 0, 32'h14, $urandom, 8'h11, 1);
    cyc(0, 6'b000010, 0, 0, 32'h20, $urandom, 8'h22, 1);
    pass(32'h30);
    cyc(0, 6'b000110, 0, 0, 32'h34, $urandom, 8'h33, 1);
    cyc(0, 6'b000110, 1, 0, 32'h34, $urandom, 8'h33, 1);
    cyc(0, 6'b000000, 1, 0, 32'h38, $urandom, 8'h44, 1);
    cyc(0, 6'b000010, 1, 0, 32'h3c, $urandom, 8'h44, 1);
    repeat (5) cyc(0, 6'b000010, 0, 0, 32'h50, $urandom, 8'h55, 0);
    cyc(0, 6'b000010, 0, 1, 32'h54, $urandom, 8'h55, 1);
    pass(32'h58);
    cyc(0, 6'b000110, 0, 0, 32'h5c, $urandom, 8'h66, 1);
    cyc(1, 6'b000110, 1, 1, 32'h60, $urandom, 8'h66, 1);
    cyc(0, 6'b000110, 0, 0, 32'h64, $urandom, 8'h77, 1);
    pass(32'h68);

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0), 6'($urandom), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 39) == 0), $urandom, $urandom, 8'($urandom),
          1'($urandom));
    end
    pass(32'h100);

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #5;
    if (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
